// File: rtl/ram_rsp_fifo.sv
// Response FIFO for ram_port_master: holds RAM read data until the consumer
// takes it. Depth is not a power of two, so pointers wrap explicitly.
module ram_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic                             pop,
    output logic [$clog2(DEPTH+1)-1:0]       occ,
    output logic [WIDTH-1:0]                 head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [OW-1:0]    occ_q, occ_d;

    // Pointer increment modulo DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers and occupancy; push and pop together leave occ unchanged.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    // Head of queue and occupancy outputs.
    always_comb begin
        head = mem_q[rptr_q];
        occ  = occ_q;
    end

endmodule

// File: rtl/ram_port_master.sv
// Initiator front end for one port of the synchronous dual-port RAM.
// Commands drive the RAM port combinationally; read data returning one
// cycle later is captured into a 3-entry response FIFO.
module ram_port_master #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [$clog2(DEPTH)-1:0] cmd_addr,
    input  logic [WIDTH-1:0]         cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic [WIDTH-1:0]         ram_din,
    input  logic [WIDTH-1:0]         ram_dout
);

    localparam int unsigned RSP_DEPTH = 3;
    localparam int unsigned OW        = $clog2(RSP_DEPTH + 1);

    logic          rdy_en_q;
    logic          rd_pend;
    logic          rd_pend_d;
    logic [OW-1:0] occ;
    logic [OW:0]   inflight;
    logic          pop;

    // Admission control uses registered state only, so a read can never
    // find the FIFO full when its data returns.
    always_comb begin
        inflight  = {1'b0, occ} + (OW + 1)'(rd_pend);
        cmd_ready = rdy_en_q & (inflight < (OW + 1)'(RSP_DEPTH));
        ram_en    = cmd_valid & cmd_ready;
        ram_we    = ram_en & cmd_we;
        ram_addr  = cmd_addr;
        ram_din   = cmd_wdata;
        rd_pend_d = ram_en & ~cmd_we;
        rsp_valid = (occ != '0);
        pop       = rsp_valid & rsp_ready;
    end

    // rdy_en holds cmd_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            rd_pend  <= rd_pend_d;
        end
    end

    ram_rsp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (ram_dout),
        .pop       (pop),
        .occ       (occ),
        .head      (rsp_rdata)
    );

endmodule
